// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives the imem request/ack handshake and redirects on taken branches.
// It holds a stalled instruction in a skid register and drains abandoned requests before refetching.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallReq,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic [31:0] PCOutF,
  output logic        IFIDEnD,
  output logic        IFIDClrD,
  output logic        IDEXClrE,
  output logic        imem_timeout
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] drain_q, drain_d;
  logic [7:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [31:0] target;

  assign target       = {PCTargetE[31:2], 2'b00};
  assign PCF          = pc_q;
  assign imem_timeout = timeout_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    drain_d   = drain_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    InstrF    = imem_rdata;
    PCOutF    = pc_q;
    IFIDEnD   = 1'b0;
    IFIDClrD  = 1'b0;
    IDEXClrE  = 1'b0;

    unique case (state_q)
      IDLE: begin
        InstrF  = 32'h0;
        PCOutF  = 32'h0;
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        IDEXClrE = StallReq;
        if (PCSrcE) begin
          pc_d     = target;
          IFIDClrD = 1'b1;
          IDEXClrE = 1'b1;
          if (!imem_ack) begin
            // The in-flight request cannot be withdrawn; remember it so it can be drained.
            drain_d = pc_q;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_q + 32'd4;
          if (StallReq) begin
            skid_d    = imem_rdata;
            skid_pc_d = pc_q;
            state_d   = HOLD;
          end else begin
            IFIDEnD = 1'b1;
          end
        end
      end
      HOLD: begin
        InstrF   = skid_q;
        PCOutF   = skid_pc_q;
        IDEXClrE = StallReq;
        if (PCSrcE) begin
          pc_d     = target;
          IFIDClrD = 1'b1;
          IDEXClrE = 1'b1;
          state_d  = FETCH;
        end else if (!StallReq) begin
          IFIDEnD = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_q;
        IDEXClrE  = StallReq;
        if (PCSrcE) begin
          pc_d     = target;
          IFIDClrD = 1'b1;
          IDEXClrE = 1'b1;
        end
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait counter tracks the current unacknowledged request; the timeout flag is sticky.
  always_comb begin
    wait_d = wait_q;
    if (imem_req && imem_ack)                    wait_d = 8'h00;
    else if (imem_req && (wait_q != 8'hFF))      wait_d = wait_q + 8'd1;
    timeout_d = timeout_q | (wait_d >= WAIT_LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      skid_q    <= 32'h0;
      skid_pc_q <= 32'h0;
      drain_q   <= 32'h0;
      wait_q    <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
      drain_q   <= drain_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: hand-computed expectations checked with immediate assertions.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallReq;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [31:0] PCOutF;
  logic        IFIDEnD;
  logic        IFIDClrD;
  logic        IDEXClrE;
  logic        imem_timeout;

  int errors = 0;
  int checks = 0;

  fetch_controller #(.RESET_PC(32'h0000_0000), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallReq(StallReq), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .PCF(PCF), .InstrF(InstrF),
    .PCOutF(PCOutF), .IFIDEnD(IFIDEnD), .IFIDClrD(IFIDClrD),
    .IDEXClrE(IDEXClrE), .imem_timeout(imem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic src, input logic [31:0] tgt, input logic stall,
                       input logic ack, input logic [31:0] rdata);
    PCSrcE = src; PCTargetE = tgt; StallReq = stall; imem_ack = ack; imem_rdata = rdata;
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_req",     {31'h0, imem_req},     32'h0);
    chk("rst_addr",    imem_addr,             32'h0);
    chk("rst_pcf",     PCF,                   32'h0);
    chk("rst_timeout", {31'h0, imem_timeout}, 32'h0);
    chk("rst_en",      {29'h0, IFIDEnD, IFIDClrD, IDEXClrE}, 32'h0);
    chk("rst_instr",   InstrF,                32'h0);
    chk("rst_pcout",   PCOutF,                32'h0);

    // Release away from the edge; request must appear within a bounded number of cycles.
    rst = 1'b1;
    n = 0;
    while (!imem_req && n < 4) begin tick(); n++; end
    chk("first_req",  {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr,         32'h0);

    // Sequential fetch with ack every cycle.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i));
      chk($sformatf("seq_addr%0d", i),  imem_addr, 32'(i * 4));
      chk($sformatf("seq_en%0d", i),    {31'h0, IFIDEnD}, 32'h1);
      chk($sformatf("seq_pcout%0d", i), PCOutF, 32'(i * 4));
      chk($sformatf("seq_instr%0d", i), InstrF, 32'hA000_0000 + 32'(i));
      tick();
    end

    // Ack at 0x8 with stall: captured into skid, bubble inserted.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hCAFE_0008);
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_en",   {31'h0, IFIDEnD},  32'h0);
    chk("stall_idex", {31'h0, IDEXClrE}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("hold_req",   {31'h0, imem_req}, 32'h0);
    chk("hold_instr", InstrF,            32'hCAFE_0008);
    chk("hold_pcout", PCOutF,            32'h8);
    chk("hold_en",    {31'h0, IFIDEnD},  32'h0);
    chk("hold_idex",  {31'h0, IDEXClrE}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("hold_rel_en",    {31'h0, IFIDEnD}, 32'h1);
    chk("hold_rel_instr", InstrF,           32'hCAFE_0008);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_000C);
    chk("after_hold_addr", imem_addr, 32'hC);
    chk("after_hold_req",  {31'h0, imem_req}, 32'h1);
    tick();

    // Redirect while 0x10 is outstanding: drain the old request.
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("redir_addr", imem_addr,          32'h10);
    chk("redir_clr",  {31'h0, IFIDClrD},  32'h1);
    chk("redir_idex", {31'h0, IDEXClrE},  32'h1);
    chk("redir_en",   {31'h0, IFIDEnD},   32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_addr", imem_addr,         32'h10);
    chk("drain_req",  {31'h0, imem_req}, 32'h1);
    chk("drain_pcf",  PCF,               32'h100);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555);
    chk("drain_ack_addr", imem_addr,        32'h10);
    chk("drain_ack_en",   {31'h0, IFIDEnD}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
    chk("post_drain_addr", imem_addr,        32'h100);
    chk("post_drain_en",   {31'h0, IFIDEnD}, 32'h1);
    tick();

    // Redirect + stall + ack together: redirect wins, target alignment forced.
    drive(1'b1, 32'h203, 1'b1, 1'b1, 32'h0000_0104);
    chk("combo_addr", imem_addr,         32'h104);
    chk("combo_clr",  {31'h0, IFIDClrD}, 32'h1);
    chk("combo_idex", {31'h0, IDEXClrE}, 32'h1);
    chk("combo_en",   {31'h0, IFIDEnD},  32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("combo_next_req",  {31'h0, imem_req}, 32'h1);
    chk("combo_next_addr", imem_addr,         32'h200);

    // Timeout: 7 unacked cycles keep the flag low, the 8th sets it.
    for (int i = 0; i < 7; i++) tick();
    chk("to_before", {31'h0, imem_timeout}, 32'h0);
    chk("to_addr",   imem_addr,             32'h200);
    tick();
    chk("to_set", {31'h0, imem_timeout}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("to_sticky", {31'h0, imem_timeout}, 32'h1);
    chk("to_pcf",    PCF,                   32'h204);
    tick();
    tick();

    // Asynchronous reset mid-wait.
    rst = 1'b0;
    #1;
    chk("mid_rst_timeout", {31'h0, imem_timeout}, 32'h0);
    chk("mid_rst_pcf",     PCF,                   32'h0);
    chk("mid_rst_req",     {31'h0, imem_req},     32'h0);
    #3;
    rst = 1'b1;
    tick();

    // Wrap: redirect to 0xFFFFFFFF aligns to 0xFFFFFFFC, next fetch wraps to 0.
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
    chk("wrap_redir_addr", imem_addr, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    chk("wrap_pcf",   PCF,              32'hFFFF_FFFC);
    chk("wrap_addr",  imem_addr,        32'hFFFF_FFFC);
    chk("wrap_pcout", PCOutF,           32'hFFFF_FFFC);
    chk("wrap_en",    {31'h0, IFIDEnD}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_zero", PCF,       32'h0);
    chk("wrap_next", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
